// File: rtl/fridge_status_tx.sv
// fridge_status_tx: serial readback of the stored fridge settings.
// Sends 11-bit frames {start, id[2:0], data[4:0], even parity, stop},
// LSB first, BIT_CYCLES clocks per bit; sel=7 dumps all five fields.
// Ports: clk, rst_n (sync, active-low), i (power), req, sel[2:0],
//   fgt/frt/fgc/frc[4:0], ice -> tx, busy, done (pulse), err (pulse).
module fridge_status_tx #(
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i,
   input  logic       req,
   input  logic [2:0] sel,
   input  logic [4:0] fgt,
   input  logic [4:0] frt,
   input  logic [4:0] fgc,
   input  logic [4:0] frc,
   input  logic       ice,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ID,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cyc_q, cyc_d;
   logic [2:0] bit_q, bit_d;
   logic [2:0] fld_q, fld_d;
   logic       dump_q, dump_d;
   logic [4:0] fgt_q, fgt_d;
   logic [4:0] frt_q, frt_d;
   logic [4:0] fgc_q, fgc_d;
   logic [4:0] frc_q, frc_d;
   logic       ice_q, ice_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic [4:0] cur_data;
   logic       parity;
   logic       cyc_end;
   logic       sel_ok;
   logic [2:0] bit_nx;

   // Field being sent comes from the snapshot, never the live inputs.
   always_comb begin
      cur_data = 5'd0;
      case (fld_q)
         3'd0:    cur_data = fgt_q;
         3'd1:    cur_data = frt_q;
         3'd2:    cur_data = fgc_q;
         3'd3:    cur_data = frc_q;
         default: cur_data = {4'b0, ice_q};
      endcase
   end

   assign parity  = ^{fld_q, cur_data};
   assign cyc_end = (cyc_q == CYC_LAST);
   assign sel_ok  = (sel <= 3'd4) || (sel == 3'd7);
   assign bit_nx  = bit_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      fld_d   = fld_q;
      dump_d  = dump_q;
      fgt_d   = fgt_q;
      frt_d   = frt_q;
      fgc_d   = fgc_q;
      frc_d   = frc_q;
      ice_d   = ice_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (!i) begin
         state_d = IDLE;
         cyc_d   = 8'd0;
         bit_d   = 3'd0;
         fld_d   = 3'd0;
         dump_d  = 1'b0;
         tx_d    = 1'b1;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_d   = 1'b1;
               busy_d = 1'b0;
               if (req && sel_ok) begin
                  fgt_d   = fgt;
                  frt_d   = frt;
                  fgc_d   = fgc;
                  frc_d   = frc;
                  ice_d   = ice;
                  dump_d  = (sel == 3'd7);
                  fld_d   = (sel == 3'd7) ? 3'd0 : sel;
                  cyc_d   = 8'd0;
                  bit_d   = 3'd0;
                  state_d = START;
                  tx_d    = 1'b0;
                  busy_d  = 1'b1;
               end else if (req) begin
                  err_d = 1'b1;
               end
            end
            START: begin
               if (cyc_end) begin
                  cyc_d   = 8'd0;
                  bit_d   = 3'd0;
                  state_d = ID;
                  tx_d    = fld_q[0];
               end else begin
                  cyc_d = cyc_q + 8'd1;
               end
            end
            ID: begin
               if (cyc_end) begin
                  cyc_d = 8'd0;
                  if (bit_q == 3'd2) begin
                     bit_d   = 3'd0;
                     state_d = DATA;
                     tx_d    = cur_data[0];
                  end else begin
                     bit_d = bit_nx;
                     tx_d  = fld_q[bit_nx[1:0]];
                  end
               end else begin
                  cyc_d = cyc_q + 8'd1;
               end
            end
            DATA: begin
               if (cyc_end) begin
                  cyc_d = 8'd0;
                  if (bit_q == 3'd4) begin
                     bit_d   = 3'd0;
                     state_d = PARITY;
                     tx_d    = parity;
                  end else begin
                     bit_d = bit_nx;
                     tx_d  = cur_data[bit_nx];
                  end
               end else begin
                  cyc_d = cyc_q + 8'd1;
               end
            end
            PARITY: begin
               if (cyc_end) begin
                  cyc_d   = 8'd0;
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  cyc_d = cyc_q + 8'd1;
               end
            end
            STOP: begin
               if (cyc_end) begin
                  cyc_d = 8'd0;
                  // A dump chains straight into the next start bit.
                  if (dump_q && (fld_q != 3'd4)) begin
                     fld_d   = fld_q + 3'd1;
                     state_d = START;
                     tx_d    = 1'b0;
                  end else begin
                     fld_d   = 3'd0;
                     dump_d  = 1'b0;
                     state_d = IDLE;
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  cyc_d = cyc_q + 8'd1;
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= 8'd0;
         bit_q   <= 3'd0;
         fld_q   <= 3'd0;
         dump_q  <= 1'b0;
         fgt_q   <= 5'd0;
         frt_q   <= 5'd0;
         fgc_q   <= 5'd0;
         frc_q   <= 5'd0;
         ice_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         fld_q   <= fld_d;
         dump_q  <= dump_d;
         fgt_q   <= fgt_d;
         frt_q   <= frt_d;
         fgc_q   <= fgc_d;
         frc_q   <= frc_d;
         ice_q   <= ice_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_fridge_status_tx.sv
// tb_fridge_status_tx: directed bench for fridge_status_tx.
// Instance u1 runs BIT_CYCLES=1, u2 runs BIT_CYCLES=2 on shared inputs.
module tb_fridge_status_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i = 1'b0;
   logic       req = 1'b0;
   logic [2:0] sel = 3'd0;
   logic [4:0] fgt = 5'd0;
   logic [4:0] frt = 5'd0;
   logic [4:0] fgc = 5'd0;
   logic [4:0] frc = 5'd0;
   logic       ice = 1'b0;
   logic       tx1, busy1, done1, err1;
   logic       tx2, busy2, done2, err2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fridge_status_tx #(.BIT_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .i(i), .req(req), .sel(sel),
      .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc), .ice(ice),
      .tx(tx1), .busy(busy1), .done(done1), .err(err1)
   );

   fridge_status_tx #(.BIT_CYCLES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .i(i), .req(req), .sel(sel),
      .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc), .ice(ice),
      .tx(tx2), .busy(busy2), .done(done2), .err(err2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req   = 1'b0;
      i     = 1'b1;
      sel   = 3'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send_req(input logic [2:0] s);
      sel = s;
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({tx1, busy1, done1, err1} !== 4'b1000) begin
         failures++;
         $display("FAIL reset u1 got=%b want=1000",
                  {tx1, busy1, done1, err1});
      end
      checks++;
      if ({tx2, busy2, done2, err2} !== 4'b1000) begin
         failures++;
         $display("FAIL reset u2 got=%b want=1000",
                  {tx2, busy2, done2, err2});
      end
   endtask

   task automatic test_fgt_frame;
      logic [10:0] st;
      int bc;
      do_reset();
      fgt = 5'b00101;
      send_req(3'd0);
      st = '0;
      bc = 0;
      for (int c = 0; c < 11; c++) begin
         st = {st[9:0], tx1};
         if (busy1) bc++;
         tick();
      end
      checks++;
      if (st !== 11'b00001010001) begin
         failures++;
         $display("FAIL fgt_frame got=%b want=00001010001", st);
      end
      checks++;
      if (bc != 11) begin
         failures++;
         $display("FAIL fgt_busy got=%0d want=11", bc);
      end
      checks++;
      if ({done1, busy1, tx1} !== 3'b101) begin
         failures++;
         $display("FAIL fgt_done got=%b want=101",
                  {done1, busy1, tx1});
      end
      tick();
      checks++;
      if (done1 !== 1'b0) begin
         failures++;
         $display("FAIL fgt_done_pulse got=%b want=0", done1);
      end
   endtask

   task automatic test_frc_frame;
      logic [10:0] st;
      do_reset();
      frc = 5'b11111;
      send_req(3'd3);
      st = '0;
      for (int c = 0; c < 11; c++) begin
         st = {st[9:0], tx1};
         tick();
      end
      checks++;
      if (st !== 11'b01101111111) begin
         failures++;
         $display("FAIL frc_frame got=%b want=01101111111", st);
      end
   endtask

   task automatic test_dump;
      logic [54:0] st;
      logic [54:0] exp;
      logic prev;
      int unst, bc, dc;
      exp = {11'b00001000011, 11'b01000100001, 11'b00101100011,
             11'b01100000001, 11'b00011000001};
      do_reset();
      fgt = 5'd1;
      frt = 5'd2;
      fgc = 5'd3;
      frc = 5'd0;
      ice = 1'b1;
      send_req(3'd7);
      st = '0;
      prev = 1'b1;
      unst = 0;
      bc = 0;
      dc = 0;
      for (int c = 0; c < 110; c++) begin
         if (c % 2 == 0) begin
            st = {st[53:0], tx2};
            prev = tx2;
         end else if (tx2 !== prev) begin
            unst++;
         end
         if (busy2) bc++;
         if (done2) dc++;
         tick();
      end
      checks++;
      if (st !== exp) begin
         failures++;
         $display("FAIL dump_frames got=%b want=%b", st, exp);
      end
      checks++;
      if (unst != 0) begin
         failures++;
         $display("FAIL dump_bit_hold got=%0d want=0", unst);
      end
      checks++;
      if (bc != 110) begin
         failures++;
         $display("FAIL dump_busy got=%0d want=110", bc);
      end
      checks++;
      if ({done2, busy2} !== 2'b10) begin
         failures++;
         $display("FAIL dump_end got=%b want=10", {done2, busy2});
      end
      for (int c = 0; c < 5; c++) begin
         if (done2) dc++;
         tick();
      end
      checks++;
      if (dc != 1) begin
         failures++;
         $display("FAIL dump_done_count got=%0d want=1", dc);
      end
   endtask

   task automatic test_invalid_sel;
      do_reset();
      send_req(3'd5);
      checks++;
      if ({err1, busy1, tx1} !== 3'b101) begin
         failures++;
         $display("FAIL inv5 got=%b want=101", {err1, busy1, tx1});
      end
      tick();
      checks++;
      if ({err1, busy1, tx1} !== 3'b001) begin
         failures++;
         $display("FAIL inv5_pulse got=%b want=001",
                  {err1, busy1, tx1});
      end
      send_req(3'd6);
      checks++;
      if ({err1, busy1} !== 2'b10) begin
         failures++;
         $display("FAIL inv6 got=%b want=10", {err1, busy1});
      end
   endtask

   task automatic test_ignored_req;
      logic [10:0] st;
      int bc;
      do_reset();
      fgt = 5'b00101;
      frc = 5'b11111;
      send_req(3'd0);
      st = '0;
      for (int c = 0; c < 11; c++) begin
         if (c == 3) begin
            sel = 3'd3;
            req = 1'b1;
         end
         if (c == 5) req = 1'b0;
         st = {st[9:0], tx1};
         tick();
      end
      checks++;
      if (st !== 11'b00001010001) begin
         failures++;
         $display("FAIL ignored_req_frame got=%b want=00001010001", st);
      end
      bc = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (busy1) bc++;
      end
      checks++;
      if (bc != 0) begin
         failures++;
         $display("FAIL ignored_req_no_second got=%0d want=0", bc);
      end
   endtask

   task automatic test_snapshot;
      logic [10:0] st;
      do_reset();
      fgt = 5'b00101;
      send_req(3'd0);
      st = '0;
      for (int c = 0; c < 11; c++) begin
         if (c == 2) fgt = 5'b11111;
         st = {st[9:0], tx1};
         tick();
      end
      checks++;
      if (st !== 11'b00001010001) begin
         failures++;
         $display("FAIL snapshot got=%b want=00001010001", st);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      fgt = 5'b00101;
      sel = 3'd0;
      req = 1'b1;
      tick();
      for (int c = 0; c < 11; c++) tick();
      checks++;
      if ({done1, busy1} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_done got=%b want=10", {done1, busy1});
      end
      tick();
      req = 1'b0;
      checks++;
      if ({done1, busy1, tx1} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_restart got=%b want=010",
                  {done1, busy1, tx1});
      end
   endtask

   task automatic test_abort_power;
      int dc;
      do_reset();
      fgt = 5'b00000;
      send_req(3'd0);
      for (int c = 0; c < 4; c++) tick();
      checks++;
      if ({busy1, tx1} !== 2'b10) begin
         failures++;
         $display("FAIL pwr_pre got=%b want=10", {busy1, tx1});
      end
      i = 1'b0;
      tick();
      checks++;
      if ({tx1, busy1, done1} !== 3'b100) begin
         failures++;
         $display("FAIL pwr_abort got=%b want=100",
                  {tx1, busy1, done1});
      end
      sel = 3'd0;
      req = 1'b1;
      dc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done1 || busy1) dc++;
      end
      req = 1'b0;
      i = 1'b1;
      checks++;
      if (dc != 0) begin
         failures++;
         $display("FAIL pwr_no_activity got=%0d want=0", dc);
      end
   endtask

   task automatic test_abort_reset;
      int dc;
      do_reset();
      fgt = 5'b00000;
      send_req(3'd0);
      for (int c = 0; c < 4; c++) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({tx1, busy1, done1, err1} !== 4'b1000) begin
         failures++;
         $display("FAIL rst_abort got=%b want=1000",
                  {tx1, busy1, done1, err1});
      end
      rst_n = 1'b1;
      dc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done1 || busy1) dc++;
      end
      checks++;
      if (dc != 0) begin
         failures++;
         $display("FAIL rst_no_activity got=%0d want=0", dc);
      end
   endtask

   initial begin
      test_reset();
      test_fgt_frame();
      test_frc_frame();
      test_dump();
      test_invalid_sel();
      test_ignored_req();
      test_snapshot();
      test_back_to_back();
      test_abort_power();
      test_abort_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fridge_status_tx.md
# fridge_status_tx

Serial readback transmitter for the fridge controller. It reads the stored settings (fridge/freezer temperature, fridge/freezer capacity, ice-maker state) and sends them out as framed serial words on a single line, one field per request or all five in a dump. It sits beside the settings-write path and consumes its stored outputs. It is the read side of the same settings interface.

## Interface

Parameters:
- BIT_CYCLES, default 4: clock cycles per serial bit. Legal range is 1..255.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, synchronous and active-low.
- i, in, 1: power. Low forces an abort to IDLE.
- req, in, 1: request. Sampled only in IDLE.
- sel, in, 3: field select. 0 = fgt, 1 = frt, 2 = fgc, 3 = frc, 4 = ice, 7 = dump all. 5 and 6 are invalid.
- fgt, in, 5: fridge temperature.
- frt, in, 5: freezer temperature.
- fgc, in, 5: fridge capacity.
- frc, in, 5: freezer capacity.
- ice, in, 1: ice-maker state.
- tx, out, 1: serial line. Idles high.
- busy, out, 1: high while a frame or dump is in progress.
- done, out, 1: one-cycle pulse when a request completes.
- err, out, 1: one-cycle pulse when a request is rejected.

## Operation

- **Frame:** 11 bits, sent in this order:
  - start bit (0)
  - field ID[2:0], LSB first
  - data[4:0], LSB first
  - parity
  - stop bit (1)
- **Field data:** the ice field's data is {4'b0, ice}.
- **Parity:** even over ID and data. The count of ones across ID, data and parity is even.
- **FSM states:** IDLE, START, ID, DATA, PARITY, STOP.
  - A bit counter (0..2 in ID, 0..4 in DATA) and a cycle counter (0..BIT_CYCLES-1) step the states.
  - Each state holds tx for BIT_CYCLES × (bits in that state).
- **Accept:** in IDLE with i=1, rst_n=1, req=1 and valid sel:
  - Snapshot all five fields into internal registers.
  - Latch sel and go to START.
  - Later input changes do not affect the request in flight.
- **Invalid sel (5 or 6):** with i=1, pulse err for one cycle, stay in IDLE, leave tx high and do not assert busy.
- **Dump (sel=7):** send fields 0, 1, 2, 3, 4 back-to-back from the snapshot.
  - After each stop bit, the next start bit follows immediately, with no idle gap.
  - done pulses once, after field 4 only.
- **req while busy:** ignored, not queued.
- **req held high:** when the frame finishes, it is accepted again in the first IDLE cycle after done.
- **Power loss:** i=0 in any state gives, on the next edge, IDLE with tx=1 and busy=0.
  - No done pulse. An aborted frame is lost.
  - req is not accepted while i=0.
- **Reset:** rst_n=0 at any edge, including mid-frame, gives state IDLE, tx=1, busy=0, done=0, err=0 and counters cleared. The snapshot registers are cleared to 0.

## Timing

- **Accept edge (k):** req is sampled at edge k. Over the cycle that follows:
  - busy=1.
  - tx=0, the start bit, held for BIT_CYCLES cycles.
- **Single frame:**
  - tx carries the frame for 11×BIT_CYCLES cycles after k.
  - Then busy=0 and done=1 for exactly one cycle.
  - Then tx=1.
- **Dump:** occupies 55×BIT_CYCLES cycles, with done after the last stop-bit period.
- **err:** asserted in the cycle after the edge that samples the invalid request.
- **Back-to-back requests:** the minimum spacing between starts of consecutive single frames is 11×BIT_CYCLES + 1 cycles (one IDLE cycle).
- **Registered outputs:** all outputs are registered and glitch-free.
- **Priority:** rst_n over i over normal operation.

## Test plan

- **Single fgt frame:** BIT_CYCLES=1, reset, then i=1, fgt=5'b00101, sel=0, req pulse.
  - Required: tx = 0,0,0,0,1,0,1,0,0,0,1 over cycles 1..11.
  - busy high for those 11 cycles, done in cycle 12.
- **Single frc frame:** BIT_CYCLES=1, frc=5'b11111, sel=3.
  - Required: tx = 0,1,1,0,1,1,1,1,1,1,1 (parity 1).
- **Dump:** BIT_CYCLES=2, fgt=1, frt=2, fgc=3, frc=0, ice=1, sel=7.
  - Required: 110 busy cycles and five contiguous frames with IDs 0..4.
  - The field-4 data bits are 1,0,0,0,0.
  - Exactly one done pulse.
- **Invalid select and ignored request:**
  - sel=5 with req gives one err pulse, with busy and tx unchanged.
  - req asserted mid-frame has no effect on tx and does not trigger a second frame.
- **Snapshot holds:** change fgt from 5'b00101 to 5'b11111 in cycle 3 of a frame.
  - Required: the transmitted data is still 5'b00101.
- **Abort paths:**
  - Drop i at cycle 5 of a frame: next cycle tx=1, busy=0, and no done pulse.
  - Repeat with rst_n=0 at cycle 5: same response, plus err=0.
